// File: rtl/of_block_accumulator.sv
// rtl/of_block_accumulator.sv - saturating block accumulator for overflow-tagged 5-bit adder sums
module of_block_accumulator #(
  parameter int ACC_W     = 6,
  parameter int BLOCK_LEN = 4,
  parameter int CNT_W     = 3
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_clear,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic [4:0]       i_in_sum,
  input  logic             i_in_of,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [ACC_W-1:0] o_out_acc,
  output logic             o_out_sat,
  output logic [CNT_W-1:0] o_out_of_cnt
);

  localparam int SC_W = $clog2(BLOCK_LEN + 1);

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_HOLD} state_t;

  state_t           r_state, w_state_nxt;
  logic             r_alive;
  logic [ACC_W-1:0] r_acc, w_acc_nxt;
  logic             r_sat, w_sat_nxt;
  logic [CNT_W-1:0] r_of_cnt, w_of_cnt_nxt;
  logic [SC_W-1:0]  r_cnt, w_cnt_nxt;
  logic             w_in_xfer, w_out_xfer;
  logic [ACC_W:0]   w_sum;
  logic             w_ovf;
  logic [ACC_W-1:0] w_clamp;

  assign o_in_ready   = r_alive && (r_state != S_HOLD);
  assign o_out_valid  = (r_state == S_HOLD);
  assign o_out_acc    = r_acc;
  assign o_out_sat    = r_sat;
  assign o_out_of_cnt = r_of_cnt;

  assign w_in_xfer  = i_in_valid && o_in_ready;
  assign w_out_xfer = o_out_valid && i_out_ready;

  // One guard bit: the sum leaves the ACC_W range exactly when the top two bits differ.
  assign w_sum   = {r_acc[ACC_W-1], r_acc} + {{(ACC_W-4){i_in_sum[4]}}, i_in_sum};
  assign w_ovf   = w_sum[ACC_W] ^ w_sum[ACC_W-1];
  assign w_clamp = w_sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};

  always_comb begin
    w_state_nxt  = r_state;
    w_acc_nxt    = r_acc;
    w_sat_nxt    = r_sat;
    w_of_cnt_nxt = r_of_cnt;
    w_cnt_nxt    = r_cnt;
    if (i_clear) begin
      w_state_nxt  = S_IDLE;
      w_acc_nxt    = '0;
      w_sat_nxt    = 1'b0;
      w_of_cnt_nxt = '0;
      w_cnt_nxt    = '0;
    end else begin
      case (r_state)
        S_IDLE, S_ACCUM: begin
          if (w_in_xfer) begin
            w_cnt_nxt = r_cnt + SC_W'(1);
            if (i_in_of) begin
              if (r_of_cnt != {CNT_W{1'b1}}) w_of_cnt_nxt = r_of_cnt + CNT_W'(1);
            end else if (w_ovf) begin
              w_acc_nxt = w_clamp;
              w_sat_nxt = 1'b1;
            end else begin
              w_acc_nxt = w_sum[ACC_W-1:0];
            end
            w_state_nxt = (r_cnt == SC_W'(BLOCK_LEN - 1)) ? S_HOLD : S_ACCUM;
          end
        end
        S_HOLD: begin
          if (w_out_xfer) begin
            w_state_nxt  = S_IDLE;
            w_acc_nxt    = '0;
            w_sat_nxt    = 1'b0;
            w_of_cnt_nxt = '0;
            w_cnt_nxt    = '0;
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // r_alive holds in_ready low during reset and for the edge that releases it.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= S_IDLE;
      r_alive  <= 1'b0;
      r_acc    <= '0;
      r_sat    <= 1'b0;
      r_of_cnt <= '0;
      r_cnt    <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_alive  <= 1'b1;
      r_acc    <= w_acc_nxt;
      r_sat    <= w_sat_nxt;
      r_of_cnt <= w_of_cnt_nxt;
      r_cnt    <= w_cnt_nxt;
    end
  end

endmodule

// File: tb/tb_of_block_accumulator.sv
// tb/tb_of_block_accumulator.sv - self-checking bench for of_block_accumulator
module tb_of_block_accumulator;

  localparam int ACC_W     = 6;
  localparam int BLOCK_LEN = 4;
  localparam int CNT_W     = 3;
  localparam int ACC_MAX   = (1 << (ACC_W - 1)) - 1;
  localparam int ACC_MIN   = -(1 << (ACC_W - 1));
  localparam int OC_MAX    = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             i_rst_n = 1'b0;
  logic             i_clear = 1'b0;
  logic             i_in_valid = 1'b0;
  logic             o_in_ready;
  logic [4:0]       i_in_sum = '0;
  logic             i_in_of = 1'b0;
  logic             o_out_valid;
  logic             i_out_ready = 1'b1;
  logic [ACC_W-1:0] o_out_acc;
  logic             o_out_sat;
  logic [CNT_W-1:0] o_out_of_cnt;

  int n_total = 0;
  int n_pass  = 0;
  int qs[$];
  bit qo[$];

  of_block_accumulator #(.ACC_W(ACC_W), .BLOCK_LEN(BLOCK_LEN), .CNT_W(CNT_W)) dut (
    .i_clk(clk), .i_rst_n(i_rst_n), .i_clear(i_clear),
    .i_in_valid(i_in_valid), .o_in_ready(o_in_ready),
    .i_in_sum(i_in_sum), .i_in_of(i_in_of),
    .o_out_valid(o_out_valid), .i_out_ready(i_out_ready),
    .o_out_acc(o_out_acc), .o_out_sat(o_out_sat), .o_out_of_cnt(o_out_of_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, $signed(obs), $signed(exp));
  endtask

  // Reference: plain integer sum of accepted, non-overflowed samples, clamped after each one.
  function automatic void model(output int acc, output bit sat, output int oc);
    acc = 0; sat = 0; oc = 0;
    for (int i = 0; i < qs.size(); i++) begin
      if (qo[i]) begin
        if (oc < OC_MAX) oc++;
      end else begin
        acc = acc + qs[i];
        if (acc > ACC_MAX) begin acc = ACC_MAX; sat = 1; end
        else if (acc < ACC_MIN) begin acc = ACC_MIN; sat = 1; end
      end
    end
  endfunction

  function automatic logic [31:0] acc_out();
    return 32'($signed(o_out_acc));
  endfunction

  task automatic push(input int s, input bit o);
    int g;
    g = 0;
    i_in_valid = 1'b1; i_in_sum = 5'(s); i_in_of = o;
    while (o_in_ready !== 1'b1 && g < 20) begin @(negedge clk); g++; end
    chk("push_ready", o_in_ready, 1);
    @(negedge clk);
    qs.push_back(s); qo.push_back(o);
  endtask

  task automatic expect_result(input string tag);
    int acc, oc; bit sat;
    model(acc, sat, oc);
    chk({tag, "_valid"}, o_out_valid, 1);
    chk({tag, "_acc"}, acc_out(), 32'(acc));
    chk({tag, "_sat"}, o_out_sat, 32'(sat));
    chk({tag, "_ofcnt"}, o_out_of_cnt, 32'(oc));
  endtask

  task automatic consume(input string tag);
    i_out_ready = 1'b1;
    @(negedge clk);
    chk({tag, "_valid_drop"}, o_out_valid, 0);
    chk({tag, "_acc_cleared"}, acc_out(), 0);
    qs.delete(); qo.delete();
  endtask

  task automatic run_block(input string tag, input int s[4], input bit o[4]);
    i_out_ready = 1'b1;
    for (int i = 0; i < 4; i++) push(s[i], o[i]);
    i_in_valid = 1'b0;
    expect_result(tag);
    consume(tag);
  endtask

  initial begin
    int acc_hold, w, oc; bit sat;
    int rs[4]; bit ro[4];

    #1;
    chk("rst_ready", o_in_ready, 0);
    chk("rst_valid", o_out_valid, 0);
    chk("rst_acc", acc_out(), 0);
    chk("rst_sat", o_out_sat, 0);
    chk("rst_ofcnt", o_out_of_cnt, 0);
    @(negedge clk); @(negedge clk);
    i_rst_n = 1'b1;
    #1 chk("ready_before_edge", o_in_ready, 0);
    @(negedge clk);
    chk("ready_after_edge", o_in_ready, 1);

    run_block("plain", '{5, 3, -2, 7}, '{0, 0, 0, 0});
    run_block("sat_pos", '{15, 15, 15, 15}, '{0, 0, 0, 0});
    run_block("sat_neg", '{-16, -16, -16, -16}, '{0, 0, 0, 0});
    run_block("sat_back", '{15, 15, 15, -16}, '{0, 0, 0, 0});
    run_block("of_discard", '{4, 9, -9, 2}, '{0, 1, 1, 0});

    // Backpressure with a sample waiting upstream
    i_out_ready = 1'b0;
    for (int i = 0; i < 4; i++) push(i + 3, 0);
    i_in_valid = 1'b1; i_in_sum = 5'(6); i_in_of = 1'b0;
    model(acc_hold, sat, oc);
    for (int c = 0; c < 3; c++) begin
      chk("bp_ready", o_in_ready, 0);
      chk("bp_valid", o_out_valid, 1);
      chk("bp_acc", acc_out(), 32'(acc_hold));
      @(negedge clk);
    end
    i_out_ready = 1'b1;
    @(negedge clk);
    chk("bp_released_valid", o_out_valid, 0);
    chk("bp_released_ready", o_in_ready, 1);
    qs.delete(); qo.delete();
    push(6, 0);
    chk("bp_next_live_acc", acc_out(), 6);
    for (int i = 0; i < 3; i++) push(-i, 0);
    i_in_valid = 1'b0;
    expect_result("bp_next");
    consume("bp_next");

    // clear mid-block drops the coinciding sample
    push(10, 0); push(11, 0);
    i_in_valid = 1'b1; i_in_sum = 5'(9); i_clear = 1'b1;
    @(negedge clk);
    i_clear = 1'b0; i_in_valid = 1'b0;
    chk("clr_acc", acc_out(), 0);
    chk("clr_valid", o_out_valid, 0);
    chk("clr_ready", o_in_ready, 1);
    qs.delete(); qo.delete();
    run_block("after_clr", '{1, 2, 3, -4}, '{0, 0, 1, 0});

    // clear while holding a result
    i_out_ready = 1'b0;
    for (int i = 0; i < 4; i++) push(2, 0);
    i_in_valid = 1'b0;
    expect_result("hold_clr");
    i_clear = 1'b1;
    @(negedge clk);
    i_clear = 1'b0;
    chk("hold_clr_valid", o_out_valid, 0);
    chk("hold_clr_acc", acc_out(), 0);
    qs.delete(); qo.delete();

    // asynchronous reset after three samples
    i_out_ready = 1'b1;
    push(7, 0); push(1, 1); push(5, 0);
    i_in_valid = 1'b0;
    #2 i_rst_n = 1'b0;
    #1;
    chk("arst_acc", acc_out(), 0);
    chk("arst_ofcnt", o_out_of_cnt, 0);
    chk("arst_ready", o_in_ready, 0);
    chk("arst_valid", o_out_valid, 0);
    @(negedge clk);
    i_rst_n = 1'b1;
    qs.delete(); qo.delete();
    push(3, 0); push(4, 0); push(-1, 1);
    i_in_valid = 1'b0;
    chk("arst_no_early_valid", o_out_valid, 0);
    push(2, 0);
    i_in_valid = 1'b0;
    expect_result("arst_block");
    consume("arst_block");

    // randomized blocks with idle gaps and random output stalls
    for (int b = 0; b < 12; b++) begin
      for (int i = 0; i < 4; i++) begin
        rs[i] = int'($urandom_range(31)) - 16;
        ro[i] = ($urandom_range(3) == 0);
        if ($urandom_range(2) == 0) begin
          i_in_valid = 1'b0;
          @(negedge clk);
        end
        i_out_ready = $urandom_range(1);
        push(rs[i], ro[i]);
      end
      i_in_valid = 1'b0;
      w = $urandom_range(3);
      i_out_ready = 1'b0;
      for (int c = 0; c < w; c++) begin
        expect_result("rnd_stall");
        @(negedge clk);
      end
      expect_result("rnd");
      consume("rnd");
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1);
  end

endmodule
